// File: rtl/updown_counter.sv
// updown_counter: synchronous up/down modulo counter with parallel load.
// Produces a binary count, a registered one-hot decode for an LED bar,
// a one-cycle wrap pulse and a combinational terminal-count flag.
module updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic                    input_clock1_1,
  input  logic                    input_reset1_2,
  input  logic                    input_enable,
  input  logic                    input_down,
  input  logic                    input_load,
  input  logic [WIDTH-1:0]        input_data,
  output logic [WIDTH-1:0]        output_count,
  output logic [(1<<WIDTH)-1:0]   output_onehot,
  output logic                    output_tc,
  output logic                    output_wrap
);

  localparam int               ONEHOT_W  = 1 << WIDTH;
  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [31:0]      MODULUS_U = MODULUS;

  logic [WIDTH-1:0]    load_value;
  logic [WIDTH-1:0]    count_next;
  logic                wrap_next;
  logic [ONEHOT_W-1:0] onehot_next;
  logic                at_max;
  logic                at_zero;

  assign at_max  = (output_count == MAX_COUNT);
  assign at_zero = (output_count == '0);

  // Terminal count depends only on the present count and direction, so a
  // direction change is visible immediately without waiting for an edge.
  assign output_tc = input_down ? at_zero : at_max;

  // Out-of-range load values are clamped to the top of the count range so
  // the count can never leave 0..MODULUS-1.
  always_comb begin
    load_value = MAX_COUNT;
    if (32'(input_data) < MODULUS_U) begin
      load_value = input_data;
    end
  end

  // Next-state selection: load beats counting, and a wrap is flagged only
  // when the count actually crosses the range boundary.
  always_comb begin
    count_next = output_count;
    wrap_next  = 1'b0;
    if (input_load) begin
      count_next = load_value;
    end else if (input_enable) begin
      if (!input_down) begin
        if (at_max) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end else begin
          count_next = output_count + 1'b1;
        end
      end else begin
        if (at_zero) begin
          count_next = MAX_COUNT;
          wrap_next  = 1'b1;
        end else begin
          count_next = output_count - 1'b1;
        end
      end
    end
  end

  // Decode the next count so the registered one-hot lines up with the
  // registered binary count in the same cycle.
  always_comb begin
    onehot_next             = '0;
    onehot_next[count_next] = 1'b1;
  end

  // State registers; reset parks the counter at zero with bit 0 lit.
  always_ff @(posedge input_clock1_1 or posedge input_reset1_2) begin
    if (input_reset1_2) begin
      output_count  <= '0;
      output_onehot <= ONEHOT_W'(1);
      output_wrap   <= 1'b0;
    end else begin
      output_count  <= count_next;
      output_onehot <= onehot_next;
      output_wrap   <= wrap_next;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed checks of the up/down counter with the
// default range (MODULUS=8) and a reduced range (MODULUS=6).
module tb_updown_counter;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       down;
  logic       load;
  logic [2:0] data;

  logic [2:0] count8;
  logic [7:0] onehot8;
  logic       tc8;
  logic       wrap8;

  logic [2:0] count6;
  logic [7:0] onehot6;
  logic       tc6;
  logic       wrap6;

  int checks = 0;
  int errors = 0;

  updown_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .input_clock1_1 (clk),
    .input_reset1_2 (rst),
    .input_enable   (enable),
    .input_down     (down),
    .input_load     (load),
    .input_data     (data),
    .output_count   (count8),
    .output_onehot  (onehot8),
    .output_tc      (tc8),
    .output_wrap    (wrap8)
  );

  updown_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
    .input_clock1_1 (clk),
    .input_reset1_2 (rst),
    .input_enable   (enable),
    .input_down     (down),
    .input_load     (load),
    .input_data     (data),
    .output_count   (count6),
    .output_onehot  (onehot6),
    .output_tc      (tc6),
    .output_wrap    (wrap6)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across an edge with all controls idle, release after it.
  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    down   = 1'b0;
    load   = 1'b0;
    data   = 3'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    enable = 1'b1;
    down   = 1'b0;
    load   = 1'b0;
    data   = 3'd0;
    tick();
    checks++;
    if (count8 !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d expected 0", count8);
    end
    checks++;
    if (onehot8 !== 8'h01) begin
      errors++;
      $display("[TB] FAIL reset_onehot: got %02h expected 01", onehot8);
    end
    checks++;
    if (wrap8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_wrap: got %0b expected 0", wrap8);
    end
    checks++;
    if (tc8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_tc_up: got %0b expected 0", tc8);
    end
    down = 1'b1;
    #1;
    checks++;
    if (tc8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_tc_down: got %0b expected 1", tc8);
    end
    do_reset();
  endtask

  task automatic test_count_up();
    logic [2:0] exp_c;
    logic [7:0] exp_oh;
    do_reset();
    enable = 1'b1;
    down   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_c  = 3'(i % 8);
      exp_oh = 8'h01 << exp_c;
      checks++;
      if (count8 !== exp_c) begin
        errors++;
        $display("[TB] FAIL up_count[%0d]: got %0d expected %0d", i, count8, exp_c);
      end
      checks++;
      if (onehot8 !== exp_oh) begin
        errors++;
        $display("[TB] FAIL up_onehot[%0d]: got %02h expected %02h", i, onehot8, exp_oh);
      end
      checks++;
      if (wrap8 !== (i == 8)) begin
        errors++;
        $display("[TB] FAIL up_wrap[%0d]: got %0b expected %0b", i, wrap8, (i == 8));
      end
      checks++;
      if (tc8 !== (exp_c == 3'd7)) begin
        errors++;
        $display("[TB] FAIL up_tc[%0d]: got %0b expected %0b", i, tc8, (exp_c == 3'd7));
      end
    end
    tick();
    checks++;
    if (wrap8 !== 1'b0 || count8 !== 3'd1) begin
      errors++;
      $display("[TB] FAIL up_after_wrap: got count %0d wrap %0b expected count 1 wrap 0", count8, wrap8);
    end
  endtask

  task automatic test_count_down();
    do_reset();
    down   = 1'b1;
    #1;
    checks++;
    if (tc8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL down_tc_zero: got %0b expected 1", tc8);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (count8 !== 3'd7 || wrap8 !== 1'b1 || onehot8 !== 8'h80 || tc8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL down_wrap: got count %0d wrap %0b onehot %02h tc %0b expected 7 1 80 0",
               count8, wrap8, onehot8, tc8);
    end
    tick();
    checks++;
    if (count8 !== 3'd6 || wrap8 !== 1'b0 || onehot8 !== 8'h40) begin
      errors++;
      $display("[TB] FAIL down_step: got count %0d wrap %0b onehot %02h expected 6 0 40",
               count8, wrap8, onehot8);
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    enable = 1'b1;
    down   = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (count8 !== 3'd3) begin
      errors++;
      $display("[TB] FAIL load_setup: got %0d expected 3", count8);
    end
    load = 1'b1;
    data = 3'd5;
    tick();
    checks++;
    if (count8 !== 3'd5 || wrap8 !== 1'b0 || onehot8 !== 8'h20) begin
      errors++;
      $display("[TB] FAIL load_basic: got count %0d wrap %0b onehot %02h expected 5 0 20",
               count8, wrap8, onehot8);
    end
    load = 1'b0;
    tick();
    tick();
    checks++;
    if (count8 !== 3'd7) begin
      errors++;
      $display("[TB] FAIL load_reach7: got %0d expected 7", count8);
    end
    load = 1'b1;
    data = 3'd7;
    tick();
    checks++;
    if (count8 !== 3'd7 || wrap8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_beats_wrap: got count %0d wrap %0b expected 7 0", count8, wrap8);
    end
    data = 3'd2;
    down = 1'b1;
    tick();
    data = 3'd6;
    tick();
    checks++;
    if (count8 !== 3'd6 || onehot8 !== 8'h40) begin
      errors++;
      $display("[TB] FAIL load_back_to_back: got count %0d onehot %02h expected 6 40", count8, onehot8);
    end
    load = 1'b0;
    tick();
    checks++;
    if (count8 !== 3'd5) begin
      errors++;
      $display("[TB] FAIL load_then_down: got %0d expected 5", count8);
    end
  endtask

  task automatic test_modulus6();
    logic [2:0] exp_c;
    do_reset();
    enable = 1'b1;
    down   = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_c = 3'(i);
      checks++;
      if (count6 !== exp_c || onehot6 !== (8'h01 << exp_c) || wrap6 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL m6_up[%0d]: got count %0d onehot %02h wrap %0b expected %0d %02h 0",
                 i, count6, onehot6, wrap6, exp_c, (8'h01 << exp_c));
      end
    end
    checks++;
    if (tc6 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL m6_tc_at5: got %0b expected 1", tc6);
    end
    tick();
    checks++;
    if (count6 !== 3'd0 || wrap6 !== 1'b1 || onehot6 !== 8'h01) begin
      errors++;
      $display("[TB] FAIL m6_up_wrap: got count %0d wrap %0b onehot %02h expected 0 1 01",
               count6, wrap6, onehot6);
    end
    down = 1'b1;
    tick();
    checks++;
    if (count6 !== 3'd5 || wrap6 !== 1'b1 || onehot6 !== 8'h20) begin
      errors++;
      $display("[TB] FAIL m6_down_wrap: got count %0d wrap %0b onehot %02h expected 5 1 20",
               count6, wrap6, onehot6);
    end
    load = 1'b1;
    data = 3'd7;
    tick();
    checks++;
    if (count6 !== 3'd5 || wrap6 !== 1'b0 || onehot6[7:6] !== 2'b00) begin
      errors++;
      $display("[TB] FAIL m6_clamp: got count %0d wrap %0b onehot %02h expected 5 0 20",
               count6, wrap6, onehot6);
    end
    data = 3'd6;
    tick();
    checks++;
    if (count6 !== 3'd5 || onehot6 !== 8'h20) begin
      errors++;
      $display("[TB] FAIL m6_clamp6: got count %0d onehot %02h expected 5 20", count6, onehot6);
    end
    load = 1'b0;
  endtask

  task automatic test_hold_toggle();
    do_reset();
    enable = 1'b1;
    down   = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count8 !== 3'd4 || wrap8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold[%0d]: got count %0d wrap %0b expected 4 0", i, count8, wrap8);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b0;
    #1;
    checks++;
    if (count8 !== 3'd7 || tc8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL toggle_before: got count %0d tc %0b expected 7 1", count8, tc8);
    end
    down = 1'b1;
    #1;
    checks++;
    if (tc8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL toggle_no_edge: got tc %0b expected 0", tc8);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (count8 !== 3'd6 || wrap8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL toggle_first_edge: got count %0d wrap %0b expected 6 0", count8, wrap8);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    down   = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count8 !== 3'd0 || onehot8 !== 8'h01 || wrap8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_clear: got count %0d onehot %02h wrap %0b expected 0 01 0",
               count8, onehot8, wrap8);
    end
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (count8 !== 3'd1) begin
      errors++;
      $display("[TB] FAIL async_release: got %0d expected 1", count8);
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (count8 !== 3'd0 || wrap8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_wrap_setup: got count %0d wrap %0b expected 0 1", count8, wrap8);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (wrap8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_wrap_clear: got %0b expected 0", wrap8);
    end
    rst = 1'b0;
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    down   = 1'b0;
    load   = 1'b0;
    data   = 3'd0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load_priority();
    test_modulus6();
    test_hold_toggle();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
